// File: rtl/trap_controller.sv
// Machine-mode trap/return sequencer: picks the highest-priority MEM-stage event,
// raises trap_taken/mret_exec with the redirect PC, and owns the M-mode trap CSRs.
module trap_controller #(
  parameter logic [31:0] RESET_MTVEC    = 32'h0000_0000,
  parameter int          LOCKOUT_CYCLES = 3,
  parameter int          SYNC_STAGES    = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall_pipl,
  input  logic        mem_valid,
  input  logic [31:0] pc_mem,
  input  logic        ecall_mem,
  input  logic        ebreak_mem,
  input  logic        illegal_mem,
  input  logic        mret_mem,
  input  logic        irq_sw_i,
  input  logic        irq_timer_i,
  input  logic        irq_ext_i,
  input  logic        csr_we,
  input  logic [11:0] csr_addr,
  input  logic [31:0] csr_wdata,
  output logic [31:0] csr_rdata,
  output logic        trap_taken,
  output logic        mret_exec,
  output logic [31:0] trap_pc
);

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MIE     = 12'h304;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
  localparam logic [11:0] CSR_MIP     = 12'h344;
  localparam logic [3:0]  LOCK_INIT   = 4'(LOCKOUT_CYCLES);

  typedef enum logic {IDLE, LOCKOUT} state_t;

  state_t      state_q, state_d;
  logic [3:0]  lock_cnt_q, lock_cnt_d;

  // irq bit order everywhere: {ext, timer, sw}
  logic [SYNC_STAGES-1:0][2:0] irq_sync_q;
  logic [2:0]  mip_lv;

  logic        mstatus_mie_q, mstatus_mpie_q;
  logic [2:0]  mie_q;
  logic [31:0] mtvec_q, mepc_q, mcause_q;

  logic        take_trap, take_mret, accept;
  logic [31:0] cause, tvec_base;

  assign mip_lv = irq_sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (reset) irq_sync_q <= '0;
    else       irq_sync_q <= {irq_sync_q[SYNC_STAGES-2:0], {irq_ext_i, irq_timer_i, irq_sw_i}};
  end

  assign accept = (state_q == IDLE) && !stall_pipl && mem_valid && !reset;

  always_comb begin
    take_trap = 1'b0;
    take_mret = 1'b0;
    cause     = '0;
    if (accept) begin
      if (illegal_mem)                                   begin take_trap = 1'b1; cause = 32'd2;         end
      else if (ebreak_mem)                               begin take_trap = 1'b1; cause = 32'd3;         end
      else if (ecall_mem)                                begin take_trap = 1'b1; cause = 32'd11;        end
      else if (mstatus_mie_q && mie_q[2] && mip_lv[2])   begin take_trap = 1'b1; cause = 32'h8000_000B; end
      else if (mstatus_mie_q && mie_q[0] && mip_lv[0])   begin take_trap = 1'b1; cause = 32'h8000_0003; end
      else if (mstatus_mie_q && mie_q[1] && mip_lv[1])   begin take_trap = 1'b1; cause = 32'h8000_0007; end
      else if (mret_mem)                                 take_mret = 1'b1;
    end
  end

  assign tvec_base = {mtvec_q[31:2], 2'b00};

  always_comb begin
    trap_pc = tvec_base;
    if (take_mret)
      trap_pc = mepc_q;
    else if (mtvec_q[1:0] == 2'b01 && cause[31])
      trap_pc = tvec_base + {26'b0, cause[3:0], 2'b00};
  end

  assign trap_taken = take_trap;
  assign mret_exec  = take_mret;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      lock_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      lock_cnt_q <= lock_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    lock_cnt_d = lock_cnt_q;
    case (state_q)
      IDLE: if (take_trap || take_mret) begin
        state_d    = LOCKOUT;
        lock_cnt_d = LOCK_INIT;
      end
      LOCKOUT: begin
        if (lock_cnt_q <= 4'd1) begin
          state_d    = IDLE;
          lock_cnt_d = '0;
        end else begin
          lock_cnt_d = lock_cnt_q - 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Trap/mret updates come after the CSR write so they take precedence.
  always_ff @(posedge clk) begin
    if (reset) begin
      mstatus_mie_q  <= 1'b0;
      mstatus_mpie_q <= 1'b0;
      mie_q          <= '0;
      mtvec_q        <= RESET_MTVEC;
      mepc_q         <= '0;
      mcause_q       <= '0;
    end else begin
      if (csr_we && !stall_pipl) begin
        case (csr_addr)
          CSR_MSTATUS: begin
            mstatus_mie_q  <= csr_wdata[3];
            mstatus_mpie_q <= csr_wdata[7];
          end
          CSR_MIE:    mie_q    <= {csr_wdata[11], csr_wdata[7], csr_wdata[3]};
          CSR_MTVEC:  mtvec_q  <= csr_wdata;
          CSR_MEPC:   mepc_q   <= csr_wdata & ~32'h3;
          CSR_MCAUSE: mcause_q <= csr_wdata;
          default: ;
        endcase
      end
      if (take_trap) begin
        mepc_q         <= pc_mem & ~32'h3;
        mcause_q       <= cause;
        mstatus_mpie_q <= mstatus_mie_q;
        mstatus_mie_q  <= 1'b0;
      end else if (take_mret) begin
        mstatus_mie_q  <= mstatus_mpie_q;
        mstatus_mpie_q <= 1'b1;
      end
    end
  end

  always_comb begin
    csr_rdata = '0;
    case (csr_addr)
      CSR_MSTATUS: csr_rdata = {24'b0, mstatus_mpie_q, 3'b0, mstatus_mie_q, 3'b0};
      CSR_MIE:     csr_rdata = {20'b0, mie_q[2], 3'b0, mie_q[1], 3'b0, mie_q[0], 3'b0};
      CSR_MTVEC:   csr_rdata = mtvec_q;
      CSR_MEPC:    csr_rdata = mepc_q;
      CSR_MCAUSE:  csr_rdata = mcause_q;
      CSR_MIP:     csr_rdata = {20'b0, mip_lv[2], 3'b0, mip_lv[1], 3'b0, mip_lv[0], 3'b0};
      default: ;
    endcase
  end

endmodule

// File: tb/tb_trap_controller.sv
// Bench for trap_controller: directed scenarios plus random traffic, all
// checked against a cycle-level behavioural model of the trap CSR rules.
module tb_trap_controller;

  localparam int          LOCK = 3;
  localparam int          SYNC = 2;
  localparam logic [31:0] RMT  = 32'h0000_1000;

  logic        clk = 1'b0;
  logic        reset, stall_pipl, mem_valid;
  logic [31:0] pc_mem;
  logic        ecall_mem, ebreak_mem, illegal_mem, mret_mem;
  logic        irq_sw_i, irq_timer_i, irq_ext_i;
  logic        csr_we;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata, csr_rdata, trap_pc;
  logic        trap_taken, mret_exec;

  trap_controller #(.RESET_MTVEC(RMT), .LOCKOUT_CYCLES(LOCK), .SYNC_STAGES(SYNC)) dut (
    .clk(clk), .reset(reset), .stall_pipl(stall_pipl), .mem_valid(mem_valid),
    .pc_mem(pc_mem), .ecall_mem(ecall_mem), .ebreak_mem(ebreak_mem),
    .illegal_mem(illegal_mem), .mret_mem(mret_mem), .irq_sw_i(irq_sw_i),
    .irq_timer_i(irq_timer_i), .irq_ext_i(irq_ext_i), .csr_we(csr_we),
    .csr_addr(csr_addr), .csr_wdata(csr_wdata), .csr_rdata(csr_rdata),
    .trap_taken(trap_taken), .mret_exec(mret_exec), .trap_pc(trap_pc)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // reference model state
  bit        m_mie, m_mpie;
  bit [31:0] m_mie_reg, m_mtvec, m_mepc, m_mcause;
  int        m_lock;
  bit [2:0]  m_irq_q[$];   // {ext,timer,sw} as seen SYNC cycles later
  bit        e_trap, e_mret;
  bit [31:0] e_cause, e_pc, e_rd;

  task automatic model_reset();
    m_mie = 0; m_mpie = 0; m_mie_reg = 0; m_mtvec = RMT; m_mepc = 0; m_mcause = 0;
    m_lock = 0;
    m_irq_q.delete();
    for (int i = 0; i < SYNC; i++) m_irq_q.push_back(3'b000);
  endtask

  task automatic model_eval();
    bit [2:0]  mip;
    bit        ok;
    bit [31:0] base;
    mip = m_irq_q[0];
    ok  = (m_lock == 0) && stall_pipl == 0 && mem_valid && !reset;
    e_trap = 0; e_mret = 0; e_cause = 0;
    if (ok) begin
      if (illegal_mem)                        begin e_trap = 1; e_cause = 2;  end
      else if (ebreak_mem)                    begin e_trap = 1; e_cause = 3;  end
      else if (ecall_mem)                     begin e_trap = 1; e_cause = 11; end
      else if (m_mie && m_mie_reg[11] && mip[2]) begin e_trap = 1; e_cause = 32'h8000000B; end
      else if (m_mie && m_mie_reg[3]  && mip[0]) begin e_trap = 1; e_cause = 32'h80000003; end
      else if (m_mie && m_mie_reg[7]  && mip[1]) begin e_trap = 1; e_cause = 32'h80000007; end
      else if (mret_mem)                      e_mret = 1;
    end
    base = m_mtvec & ~32'h3;
    if (e_mret) e_pc = m_mepc;
    else if (m_mtvec[1:0] == 2'd1 && e_cause[31]) e_pc = base + 4 * (e_cause & 32'hF);
    else e_pc = base;
    case (csr_addr)
      12'h300: e_rd = {24'b0, m_mpie, 3'b0, m_mie, 3'b0};
      12'h304: e_rd = m_mie_reg;
      12'h305: e_rd = m_mtvec;
      12'h341: e_rd = m_mepc;
      12'h342: e_rd = m_mcause;
      12'h344: e_rd = {20'b0, mip[2], 3'b0, mip[1], 3'b0, mip[0], 3'b0};
      default: e_rd = 0;
    endcase
  endtask

  task automatic model_next();
    bit old_mie, old_mpie;
    if (reset) begin
      model_reset();
      return;
    end
    old_mie = m_mie; old_mpie = m_mpie;
    if (csr_we && !stall_pipl) begin
      case (csr_addr)
        12'h300: begin m_mie = csr_wdata[3]; m_mpie = csr_wdata[7]; end
        12'h304: m_mie_reg = csr_wdata & 32'h888;
        12'h305: m_mtvec   = csr_wdata;
        12'h341: m_mepc    = csr_wdata & ~32'h3;
        12'h342: m_mcause  = csr_wdata;
        default: ;
      endcase
    end
    if (e_trap) begin
      m_mepc = pc_mem & ~32'h3; m_mcause = e_cause; m_mpie = old_mie; m_mie = 0; m_lock = LOCK;
    end else if (e_mret) begin
      m_mie = old_mpie; m_mpie = 1; m_lock = LOCK;
    end else if (m_lock > 0) begin
      m_lock--;
    end
    m_irq_q.push_back({irq_ext_i, irq_timer_i, irq_sw_i});
    void'(m_irq_q.pop_front());
  endtask

  task automatic settle();
    #1;
    model_eval();
    chk("trap_taken", {31'b0, trap_taken}, {31'b0, e_trap});
    chk("mret_exec", {31'b0, mret_exec}, {31'b0, e_mret});
    chk("csr_rdata", csr_rdata, e_rd);
    if (e_trap || e_mret) chk("trap_pc", trap_pc, e_pc);
  endtask

  task automatic advance();
    model_next();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic cycle();
    settle();
    advance();
  endtask

  task automatic idle_in();
    reset = 0; stall_pipl = 0; mem_valid = 0; pc_mem = 0;
    ecall_mem = 0; ebreak_mem = 0; illegal_mem = 0; mret_mem = 0;
    csr_we = 0; csr_addr = 12'h7C0; csr_wdata = 0;
  endtask

  task automatic rd(input string tag, input logic [11:0] a, input logic [31:0] exp);
    idle_in();
    csr_addr = a;
    settle();
    chk(tag, csr_rdata, exp);
    advance();
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d);
    idle_in();
    csr_we = 1; csr_addr = a; csr_wdata = d;
    cycle();
    csr_we = 0;
  endtask

  localparam int NADDR = 7;
  logic [11:0] addr_tab [NADDR] = '{12'h300, 12'h304, 12'h305, 12'h341, 12'h342, 12'h344, 12'h7C0};

  initial begin
    bit seen;
    idle_in();
    irq_sw_i = 0; irq_timer_i = 0; irq_ext_i = 0;
    reset = 1;
    repeat (2) @(posedge clk);
    model_reset();
    @(negedge clk);
    reset = 0;

    // reset values
    rd("rst_mstatus", 12'h300, 0);
    rd("rst_mie", 12'h304, 0);
    rd("rst_mtvec", 12'h305, RMT);
    rd("rst_mepc", 12'h341, 0);
    rd("rst_mcause", 12'h342, 0);
    rd("rst_mip", 12'h344, 0);

    // illegal instruction, direct vector
    wr(12'h305, 32'h100);
    idle_in(); mem_valid = 1; illegal_mem = 1; pc_mem = 32'h40;
    settle();
    chk("ill_taken", {31'b0, trap_taken}, 1);
    chk("ill_pc", trap_pc, 32'h100);
    advance();
    rd("ill_mepc", 12'h341, 32'h40);
    rd("ill_mcause", 12'h342, 2);

    // timer interrupt through the synchroniser, vectored mode
    wr(12'h300, 32'h8);
    wr(12'h304, 32'h80);
    wr(12'h305, 32'h101);
    irq_timer_i = 1;
    seen = 0;
    for (int i = 0; i < 12 && !seen; i++) begin
      idle_in(); mem_valid = 1; pc_mem = 32'h60;
      settle();
      if (trap_taken) begin
        seen = 1;
        chk("tmr_pc", trap_pc, 32'h11C);
      end
      advance();
    end
    if (!seen) chk("tmr_timeout", 0, 1);
    irq_timer_i = 0;
    rd("tmr_mcause", 12'h342, 32'h80000007);
    rd("tmr_mstatus", 12'h300, 32'h80);
    rd("tmr_mepc", 12'h341, 32'h60);

    // mret, then a second one inside the lockout window
    wr(12'h341, 32'h44);
    idle_in(); repeat (4) cycle();
    mem_valid = 1; mret_mem = 1;
    settle();
    chk("mret_exec", {31'b0, mret_exec}, 1);
    chk("mret_pc", trap_pc, 32'h44);
    advance();
    settle();
    chk("mret_lockout", {31'b0, mret_exec}, 0);
    advance();
    rd("mret_mstatus", 12'h300, 32'h88);

    // stalled ecall
    idle_in(); repeat (4) cycle();
    mem_valid = 1; ecall_mem = 1; pc_mem = 32'h70; stall_pipl = 1;
    for (int i = 0; i < 4; i++) begin
      settle();
      chk("stall_no_trap", {31'b0, trap_taken}, 0);
      advance();
    end
    stall_pipl = 0;
    settle();
    chk("unstall_trap", {31'b0, trap_taken}, 1);
    chk("unstall_pc", trap_pc, 32'h100);
    advance();

    // trap update of mepc beats a same-cycle CSR write
    idle_in(); repeat (4) cycle();
    csr_we = 1; csr_addr = 12'h341; csr_wdata = 32'h200;
    mem_valid = 1; ecall_mem = 1; pc_mem = 32'h80;
    cycle();
    rd("mepc_trap_wins", 12'h341, 32'h80);
    wr(12'h341, 32'h203);
    rd("mepc_align", 12'h341, 32'h200);

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      reset       = ($urandom_range(0, 199) == 0);
      stall_pipl  = ($urandom_range(0, 4) == 0);
      mem_valid   = ($urandom_range(0, 3) != 0);
      pc_mem      = $urandom & ~32'h3;
      illegal_mem = ($urandom_range(0, 15) == 0);
      ebreak_mem  = ($urandom_range(0, 15) == 0);
      ecall_mem   = ($urandom_range(0, 15) == 0);
      mret_mem    = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 9) == 0) irq_sw_i    = ~irq_sw_i;
      if ($urandom_range(0, 9) == 0) irq_timer_i = ~irq_timer_i;
      if ($urandom_range(0, 9) == 0) irq_ext_i   = ~irq_ext_i;
      csr_we    = ($urandom_range(0, 5) == 0);
      csr_addr  = addr_tab[$urandom_range(0, NADDR - 1)];
      csr_wdata = $urandom;
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
